// File: rtl/tinychip_pkg.sv
// Shared TinyChip core types: sequencer states, opcodes, instruction fields
// and the instruction classifier used by core_sequencer.
package tinychip_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_DONE   = 3'd6
   } seq_state_t;

   typedef enum logic [1:0] {
      CLS_BRANCH = 2'd0,
      CLS_LOAD   = 2'd1,
      CLS_STORE  = 2'd2,
      CLS_ALU    = 2'd3
   } instr_class_t;

   localparam logic [2:0] OP_BEQ = 3'b010;
   localparam logic [2:0] OP_BNE = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam logic [8:0] HALT_INSTR = 9'h1FF;

   localparam int unsigned IR_W        = 9;
   localparam int unsigned IR_BIT_TYPE = 8;
   localparam int unsigned IR_OP_HI    = 7;
   localparam int unsigned IR_OP_LO    = 5;
   localparam int unsigned IR_RD_HI    = 4;
   localparam int unsigned IR_RD_LO    = 3;
   localparam int unsigned IR_RO_HI    = 2;
   localparam int unsigned IR_RO_LO    = 1;
   localparam int unsigned IR_FUNCT    = 0;

   // Only bit_type=1 forms of beq/bne/lw/sw leave the plain ALU path.
   function automatic instr_class_t instr_class(input logic [IR_W-1:0] instr);
      instr_class_t cls;
      logic [2:0]   op;
      op  = instr[IR_OP_HI:IR_OP_LO];
      cls = CLS_ALU;
      if (instr[IR_BIT_TYPE]) begin
         case (op)
            OP_BEQ, OP_BNE: cls = CLS_BRANCH;
            OP_LW:          cls = CLS_LOAD;
            OP_SW:          cls = CLS_STORE;
            default:        cls = CLS_ALU;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the TinyChip core.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            begin execution at pc 0 (IDLE/DONE only)
//   instr_addr       pc to instruction memory; instr_in returns the word
//   ir               latched instruction
//   br_taken/target  branch outcome from datapath, used in EXEC
//   alu_en, mem_read, mem_write, rf_write   datapath strobes (registered)
//   mem_ack          data memory completion
//   busy, done, err  status; err is a sticky MEM timeout flag
//   instr_count      saturating retired-instruction count
module core_sequencer
   import tinychip_pkg::*;
#(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [PC_W-1:0]   instr_addr,
   input  logic [8:0]        instr_in,
   output logic [8:0]        ir,
   input  logic              br_taken,
   input  logic [PC_W-1:0]   br_target,
   output logic              alu_en,
   output logic              mem_read,
   output logic              mem_write,
   input  logic              mem_ack,
   output logic              rf_write,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   seq_state_t        state_q, state_nx;
   logic [PC_W-1:0]   pc_q, pc_nx;
   logic [8:0]        ir_q, ir_nx;
   logic [WAIT_W-1:0] wait_q, wait_nx;
   logic [CNT_W-1:0]  cnt_q, cnt_nx;
   logic              err_q, err_nx;
   logic              retire;
   instr_class_t      cls;

   assign cls = instr_class(ir_q);

   // Next-state and datapath-register update logic.
   always_comb begin
      state_nx = state_q;
      pc_nx    = pc_q;
      ir_nx    = ir_q;
      wait_nx  = wait_q;
      cnt_nx   = cnt_q;
      err_nx   = err_q;
      retire   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = S_FETCH;
               pc_nx    = '0;
               cnt_nx   = '0;
               err_nx   = 1'b0;
            end
         end
         S_FETCH: begin
            ir_nx    = instr_in;
            state_nx = S_DECODE;
         end
         S_DECODE: begin
            state_nx = (ir_q == HALT_INSTR) ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            case (cls)
               CLS_BRANCH: begin
                  pc_nx    = br_taken ? br_target : pc_q + PC_W'(1);
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end
               CLS_LOAD, CLS_STORE: begin
                  wait_nx  = '0;
                  state_nx = S_MEM;
               end
               default: state_nx = S_WB;
            endcase
         end
         S_MEM: begin
            // Ack wins even on the last allowed wait cycle.
            if (mem_ack) begin
               if (cls == CLS_LOAD) begin
                  state_nx = S_WB;
               end else begin
                  pc_nx    = pc_q + PC_W'(1);
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
               err_nx   = 1'b1;
               state_nx = S_DONE;
            end else begin
               wait_nx = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            pc_nx    = pc_q + PC_W'(1);
            retire   = 1'b1;
            state_nx = S_FETCH;
         end
         default: state_nx = S_IDLE;
      endcase
      if (retire && (cnt_q != '1)) begin
         cnt_nx = cnt_q + CNT_W'(1);
      end
   end

   // State, datapath registers and strobes decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         wait_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         alu_en    <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         rf_write  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_nx;
         pc_q      <= pc_nx;
         ir_q      <= ir_nx;
         wait_q    <= wait_nx;
         cnt_q     <= cnt_nx;
         err_q     <= err_nx;
         alu_en    <= (state_nx == S_EXEC);
         mem_read  <= (state_nx == S_MEM) && (cls == CLS_LOAD);
         mem_write <= (state_nx == S_MEM) && (cls == CLS_STORE);
         rf_write  <= (state_nx == S_WB);
         busy      <= (state_nx != S_IDLE) && (state_nx != S_DONE);
         done      <= (state_nx == S_DONE);
      end
   end

   assign instr_addr  = pc_q;
   assign ir          = ir_q;
   assign err         = err_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: ALU/HALT, branches, load with wait,
// store timeout and immediate ack, pc wrap, counter saturation, mid-MEM reset.
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  instr_addr;
   logic [8:0]  instr_in;
   logic [8:0]  ir;
   logic        br_taken;
   logic [7:0]  br_target;
   logic        alu_en, mem_read, mem_write, mem_ack, rf_write;
   logic        busy, done, err;
   logic [15:0] instr_count;

   // Narrow-counter copy to observe saturation within a short program.
   logic [7:0]  s_instr_addr;
   logic [8:0]  s_ir;
   logic        s_alu_en, s_mem_read, s_mem_write, s_rf_write, s_busy, s_done, s_err;
   logic [1:0]  s_instr_count;

   logic [8:0]  imem [256];
   int          checks = 0;
   int          errors = 0;
   int          rf_cnt, rd_cnt, wr_cnt;

   always #5 clk = ~clk;

   assign instr_in = imem[instr_addr];

   core_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr),
      .instr_in(instr_in), .ir(ir), .br_taken(br_taken), .br_target(br_target),
      .alu_en(alu_en), .mem_read(mem_read), .mem_write(mem_write),
      .mem_ack(mem_ack), .rf_write(rf_write), .busy(busy), .done(done),
      .err(err), .instr_count(instr_count)
   );

   core_sequencer #(.PC_W(8), .MEM_TIMEOUT(15), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .start(start), .instr_addr(s_instr_addr),
      .instr_in(imem[s_instr_addr]), .ir(s_ir), .br_taken(br_taken),
      .br_target(br_target), .alu_en(s_alu_en), .mem_read(s_mem_read),
      .mem_write(s_mem_write), .mem_ack(mem_ack), .rf_write(s_rf_write),
      .busy(s_busy), .done(s_done), .err(s_err), .instr_count(s_instr_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; br_taken = 1'b0; br_target = 8'h00; mem_ack = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 9'h000;
      cyc(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_strobes", 32'({alu_en, mem_read, mem_write, rf_write}), 32'd0);
      check("rst_pc", 32'(instr_addr), 32'd0);
      reset = 1'b0;

      // stray ack in IDLE
      mem_ack = 1'b1;
      cyc(3);
      check("idle_ack_busy", 32'(busy), 32'd0);
      check("idle_ack_rd", 32'(mem_read), 32'd0);
      mem_ack = 1'b0;

      // Program 1: add, HALT
      imem[0] = 9'h00C; imem[1] = 9'h1FF;
      start = 1'b1; cyc(1); start = 1'b0;
      rf_cnt = 0;
      for (int c = 1; c <= 7; c++) begin
         if (c > 1) cyc(1);
         if (rf_write) rf_cnt++;
         if (c == 1) check("p1_fetch_busy", 32'(busy), 32'd1);
         if (c == 2) check("p1_ir", 32'(ir), 32'h00C);
         if (c == 3) check("p1_alu_en", 32'(alu_en), 32'd1);
         if (c == 4) check("p1_rf_write", 32'(rf_write), 32'd1);
         if (c == 6) check("p1_not_done_early", 32'(done), 32'd0);
      end
      check("p1_done", 32'(done), 32'd1);
      check("p1_rf_cycles", 32'(rf_cnt), 32'd1);
      check("p1_count", 32'(instr_count), 32'd1);
      check("p1_err", 32'(err), 32'd0);

      // Program 2: branches, load wait, start during EXEC, pc wrap, saturation
      imem[8'h00] = 9'h140; imem[8'h20] = 9'h160; imem[8'h21] = 9'h180;
      imem[8'h22] = 9'h140; imem[8'hFF] = 9'h00C; imem[8'h30] = 9'h1FF;
      imem[8'h01] = 9'h000;
      br_taken = 1'b1; br_target = 8'h20;
      start = 1'b1; cyc(1); start = 1'b0;
      check("p2_pc0", 32'(instr_addr), 32'h00);
      cyc(3);
      check("beq_taken", 32'(instr_addr), 32'h20);
      br_taken = 1'b0;
      cyc(3);
      check("bne_not_taken", 32'(instr_addr), 32'h21);
      rd_cnt = 0; rf_cnt = 0;
      for (int c = 7; c <= 14; c++) begin
         if (c > 7) cyc(1);
         if (mem_read) rd_cnt++;
         if (rf_write) rf_cnt++;
         mem_ack = mem_read && (rd_cnt == 4);
      end
      cyc(1);
      check("lw_next_pc", 32'(instr_addr), 32'h22);
      check("lw_read_cycles", 32'(rd_cnt), 32'd4);
      check("lw_rf_cycles", 32'(rf_cnt), 32'd1);
      br_taken = 1'b1; br_target = 8'hFF;
      cyc(2);
      start = 1'b1; cyc(1); start = 1'b0;
      check("start_in_exec_ignored", 32'(instr_addr), 32'hFF);
      cyc(4);
      check("pc_wrap", 32'(instr_addr), 32'h00);
      br_target = 8'h30;
      cyc(3);
      check("beq_to_halt", 32'(instr_addr), 32'h30);
      cyc(2);
      check("p2_done", 32'(done), 32'd1);
      check("p2_count", 32'(instr_count), 32'd6);
      check("sat_count", 32'(s_instr_count), 32'd3);
      br_taken = 1'b0;

      // Program 3: store timeout
      imem[0] = 9'h1A0; imem[1] = 9'h1FF;
      start = 1'b1; cyc(1); start = 1'b0;
      wr_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) cyc(1);
         if (mem_write) wr_cnt++;
         if (c == 19) check("to_err_not_early", 32'(err), 32'd0);
      end
      check("to_write_cycles", 32'(wr_cnt), 32'd16);
      check("to_done", 32'(done), 32'd1);
      check("to_err", 32'(err), 32'd1);
      check("to_count", 32'(instr_count), 32'd0);

      // restart clears err; store with ack held high (stray ack outside MEM ignored)
      mem_ack = 1'b1;
      start = 1'b1; cyc(1); start = 1'b0;
      check("err_cleared", 32'(err), 32'd0);
      check("restart_pc0", 32'(instr_addr), 32'h00);
      wr_cnt = 0;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) cyc(1);
         if (mem_write) wr_cnt++;
      end
      cyc(1);
      check("sw_fast_pc", 32'(instr_addr), 32'h01);
      check("sw_fast_writes", 32'(wr_cnt), 32'd1);
      cyc(2);
      check("sw_fast_done", 32'(done), 32'd1);
      check("sw_fast_count", 32'(instr_count), 32'd1);
      mem_ack = 1'b0;

      // Program 4: reset in the middle of MEM
      imem[0] = 9'h180;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(3);
      check("mid_mem_read", 32'(mem_read), 32'd1);
      reset = 1'b1; cyc(1);
      check("mr_strobes", 32'({alu_en, mem_read, mem_write, rf_write}), 32'd0);
      check("mr_status", 32'({busy, done, err}), 32'd0);
      check("mr_pc", 32'(instr_addr), 32'h00);
      check("mr_ir", 32'(ir), 32'h000);
      check("mr_count", 32'(instr_count), 32'd0);
      reset = 1'b0;
      mem_ack = 1'b1; cyc(2); mem_ack = 1'b0;
      check("post_reset_idle", 32'({busy, done}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the TinyChip core: owns the program counter and instruction register, and steps every 9-bit instruction through FETCH/DECODE/EXEC/MEM/WB. Drives the enable strobes of the register file, ALU and data memory. Sits above the control decoder, register file, ALU core and data memory, replacing ad-hoc per-opcode sequencing in the top-level controller. Branch conditions and targets are computed in the datapath and returned to this block.

## Interface
- PC_W, 8, program counter / instruction address width
- MEM_TIMEOUT, 15, max MEM-state cycles waiting for mem_ack before error halt
- CNT_W, 16, retired-instruction counter width
- clk  in  1  clock; all state changes on posedge clk
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at pc 0; sampled only in IDLE or DONE
- instr_addr  out  PC_W  current pc, to instruction memory (async read)
- instr_in  in  9  instruction word from instruction memory
- ir  out  9  latched instruction; field layout: [8] bit_type, [7:5] opcode, [4:3] rd, [2:1] ro, [0] funct
- br_taken  in  1  branch condition from datapath, valid during EXEC
- br_target  in  PC_W  branch target from datapath, valid during EXEC
- alu_en  out  1  ALU result capture strobe
- mem_read, mem_write  out  1 each  data memory request, held through MEM
- mem_ack  in  1  data memory completion
- rf_write  out  1  register-file write strobe
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- err  out  1  sticky timeout flag, high in DONE after a timeout
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
- IDLE --start--> FETCH with pc=0 and instr_count=0.
- FETCH: instr_addr=pc; ir<=instr_in at the end of the cycle. Go to DECODE.
- DECODE: if ir==9'h1FF (HALT), go to DONE; HALT is not counted. Otherwise go to EXEC.
- EXEC: alu_en=1 for one cycle. Instruction classes:
  - Branch (bit_type=1, opcode 010 beq or 011 bne): pc<=br_taken ? br_target : pc+1. Retire, then FETCH.
  - Load (bit_type=1, opcode 100): go to MEM with mem_read.
  - Store (bit_type=1, opcode 101): go to MEM with mem_write.
  - All others (ALU, srl, slt, immediate forms): go to WB.
- MEM: mem_read or mem_write is asserted every cycle in the state. A wait counter starts at 0 on entry.
  - mem_ack=1: a load goes to WB; a store does pc<=pc+1, retires and goes to FETCH.
  - Wait counter reaches MEM_TIMEOUT with no ack: deassert the strobe, set err, go to DONE. The instruction is not retired.
- WB: rf_write=1 for one cycle; pc<=pc+1; retire; go to FETCH.
- Retire: instr_count increments and saturates at all-ones.
- DONE: done=1, pc frozen. start -> FETCH with pc=0; clears err and instr_count.
- pc+1 wraps from 2^PC_W-1 to 0 without error.
- mem_ack outside MEM is ignored. start while busy is ignored. br_taken and br_target outside EXEC are ignored.

## Timing
- Reset (any state, including mid-MEM): state=IDLE, pc=0, ir=0, alu_en=mem_read=mem_write=rf_write=0, busy=0, done=0, err=0, instr_count=0. Outputs are low in the cycle after reset is asserted.
- All strobes are Moore outputs of the state register and glitch-free.
- Cycles per instruction, with start accepted at edge 0 and FETCH in cycle 1:
  - ALU: 4 (FETCH, DECODE, EXEC, WB).
  - Branch: 3.
  - Store: 4 + (ack wait cycles).
  - Load: 5 + (ack wait cycles).
- If mem_ack is high in the first MEM cycle, MEM lasts exactly 1 cycle.
- Timeout: err rises after MEM_TIMEOUT+1 MEM cycles.
- HALT: done rises 2 cycles after HALT enters FETCH.

## Structure
- tinychip_pkg holds:
  - the seq_state_t enum;
  - opcode constants (OP_BEQ=3'b010, OP_BNE=3'b011, OP_LW=3'b100, OP_SW=3'b101, OP_SRL=3'b110, OP_SLT=3'b111);
  - HALT_INSTR=9'h1FF;
  - ir field index constants;
  - an instr_class function returning {BRANCH, LOAD, STORE, ALU}.
- No sub-module: a single state register plus the pc, ir, wait counter and retire counter.

## Test plan
- Reset, start; program {ALU add, HALT} -> ir=add in cycle 2, rf_write in cycle 4 only, done at cycle 7, instr_count=1, err=0.
- beq with br_taken=1, br_target=8'h20 -> instr_addr=8'h20 in the next FETCH. Same instruction with br_taken=0 -> pc+1. Each costs 3 cycles.
- lw with mem_ack delayed 3 cycles -> mem_read high exactly 4 cycles, then rf_write 1 cycle; total 8 cycles.
- sw with mem_ack never asserted, MEM_TIMEOUT=15 -> mem_write high 16 cycles, then done=1, err=1, instr_count unchanged; start clears err and restarts at pc 0.
- pc at 8'hFF executing an ALU instruction -> next instr_addr=8'h00. Preload instr_count at all-ones -> stays all-ones after retire.
- reset asserted mid-MEM with mem_read high -> next cycle all outputs at reset values; stray mem_ack in IDLE and start pulses during EXEC have no effect.
